// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler: drains NCH first-word-fall-through FIFOs into one registered
// valid/ready stream, round-robin between channels with at most BURST pops per grant.
module fifo_rd_arbiter #(
    parameter int NCH   = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic [NCH-1:0]           rempty,
    input  logic [NCH*DSIZE-1:0]     rdata,
    input  logic [NCH-1:0]           ch_en,
    output logic [NCH-1:0]           rinc,
    output logic                     out_valid,
    output logic [DSIZE-1:0]         out_data,
    output logic [$clog2(NCH)-1:0]   out_ch,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam int CW   = $clog2(NCH);
    localparam int CW1  = CW + 1;
    localparam int CNTW = $clog2(BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]      state;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   grant;
    logic [CW-1:0]   grant_nxt;
    logic [CW-1:0]   grant_inc;
    logic [CNTW-1:0] cnt;
    logic [NCH-1:0]  elig;
    logic            any_elig;
    logic            cur_elig;
    logic            pop;
    logic            last_beat;
    logic [CW1-1:0]  cand;
    logic [DSIZE-1:0] rdata_ch [NCH];

    assign elig      = ch_en & ~rempty;
    assign cur_elig  = elig[grant];
    assign pop       = (state == GRANT) & cur_elig & (~out_valid | out_ready);
    assign last_beat = (cnt == CNTW'(BURST - 1));
    assign grant_inc = (grant == CW'(NCH - 1)) ? '0 : grant + CW'(1);
    assign busy      = (state == GRANT);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            rdata_ch[i] = rdata[i*DSIZE +: DSIZE];
        end
    end

    // First eligible channel at or after rr_ptr; the wrap is a subtract so NCH need not be 2^k.
    always_comb begin
        any_elig  = 1'b0;
        grant_nxt = '0;
        cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, rr_ptr} + CW1'(k);
            if (cand >= CW1'(NCH)) begin
                cand = cand - CW1'(NCH);
            end
            if (!any_elig && elig[cand[CW-1:0]]) begin
                any_elig  = 1'b1;
                grant_nxt = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        rinc = '0;
        if (pop) begin
            rinc[grant] = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        grant <= grant_nxt;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (pop) begin
                        cnt <= cnt + CNTW'(1);
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= grant_inc;
                        end
                    end else if (!cur_elig) begin
                        state  <= IDLE;
                        rr_ptr <= grant_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: a pop overwrites the slot only when it is empty or being accepted.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= rdata_ch[grant];
            out_ch    <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: queue-backed FIFO models feed the DUT, and a transaction-level
// round-robin model predicts the delivered (channel, data) stream.
module tb_fifo_rd_arbiter;
    localparam int NCH   = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;
    localparam int CW    = 2;

    typedef logic [CW+DSIZE-1:0] word_t;

    logic                 rclk = 1'b0;
    logic                 rrst_n;
    logic [NCH-1:0]       rempty = '1;
    logic [NCH*DSIZE-1:0] rdata = '0;
    logic [NCH-1:0]       ch_en = '0;
    logic [NCH-1:0]       rinc;
    logic                 out_valid;
    logic [DSIZE-1:0]     out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_ready = 1'b1;
    logic                 busy;

    fifo_rd_arbiter #(.NCH(NCH), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .ch_en(ch_en),
        .rinc(rinc), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 rclk = ~rclk;

    logic [DSIZE-1:0] fq [NCH][$];
    word_t got[$];
    word_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int model_ptr = 0;
    int cyc = 0;
    int first_pop = -1;
    int last_pop = -1;
    int onehot_err = 0;
    int bad_pop = 0;
    int stall_pop = 0;
    int hold_err = 0;
    int pop_cnt [NCH] = '{default: 0};
    logic [NCH-1:0]   pop_latch = '0;
    logic             prev_stall = 1'b0;
    logic [DSIZE-1:0] prev_d = '0;
    logic [CW-1:0]    prev_c = '0;

    // FIFO models: pop on the edge after rinc was seen, flags visible just after the edge.
    always @(posedge rclk) begin
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (pop_latch[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            rempty[i] = (fq[i].size() == 0);
            rdata[i*DSIZE +: DSIZE] = (fq[i].size() == 0) ? '0 : fq[i][0];
        end
    end

    always @(negedge rclk) begin
        cyc++;
        if (!rrst_n) begin
            pop_latch  = '0;
            prev_stall = 1'b0;
        end else begin
            if (out_valid && out_ready) got.push_back({out_ch, out_data});
            if ($countones(rinc) > 1) onehot_err++;
            for (int i = 0; i < NCH; i++) begin
                if (rinc[i]) begin
                    pop_cnt[i]++;
                    if (rempty[i] || !ch_en[i]) bad_pop++;
                end
            end
            if (rinc != '0) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (out_valid && !out_ready && rinc != '0) stall_pop++;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_d || out_ch !== prev_c)) hold_err++;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_c     = out_ch;
            pop_latch  = rinc;
        end
    end

    task automatic load(input int ch, input int n);
        for (int j = 0; j < n; j++) fq[ch].push_back(DSIZE'($urandom));
    endtask

    task automatic clear_all();
        for (int i = 0; i < NCH; i++) fq[i].delete();
    endtask

    // Whole-grant view: pick the next eligible channel from the pointer, take up to BURST words.
    function automatic void model_build();
        int pos [NCH];
        int found;
        int t;
        exp_q.delete();
        for (int i = 0; i < NCH; i++) pos[i] = 0;
        forever begin
            found = -1;
            for (int k = 0; k < NCH; k++) begin
                int i;
                i = (model_ptr + k) % NCH;
                if (found < 0 && ch_en[i] && pos[i] < fq[i].size()) found = i;
            end
            if (found < 0) break;
            t = fq[found].size() - pos[found];
            if (t > BURST) t = BURST;
            for (int j = 0; j < t; j++) exp_q.push_back({CW'(found), fq[found][pos[found] + j]});
            pos[found] += t;
            model_ptr = (found + 1) % NCH;
        end
    endfunction

    task automatic run_until(input int n, input int budget, input bit rnd, output bit ok);
        int c;
        c  = 0;
        ok = 1'b1;
        while (got.size() < n) begin
            if (c >= budget) begin
                ok = 1'b0;
                break;
            end
            @(posedge rclk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            c++;
        end
        out_ready = 1'b1;
    endtask

    task automatic settle();
        repeat (6) @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        int b;
        bit ok;
        rrst_n = 1'b0;
        #1;
        checks++;
        if (rinc !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_init rinc=%b ov=%b od=%h oc=%0d busy=%b want all zero", rinc, out_valid, out_data, out_ch, busy);
        end
        repeat (3) @(negedge rclk);
        #1 rrst_n = 1'b1;
        @(negedge rclk); #1;
        ch_en = '1;
        for (int i = 0; i < NCH; i++) load(i, 3);
        repeat (4) @(posedge rclk);
        @(negedge rclk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_preburst busy=%b want 1", busy);
        end
        rrst_n = 1'b0;
        #1;
        checks++;
        if (rinc !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midburst rinc=%b ov=%b busy=%b want 0/0/0", rinc, out_valid, busy);
        end
        clear_all();
        repeat (2) @(negedge rclk);
        #1 rrst_n = 1'b1;
        model_ptr = 0;
        settle();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after ov=%b busy=%b want 0/0", out_valid, busy);
        end
        @(negedge rclk); #1;
        for (int i = 0; i < NCH; i++) load(i, 2);
        model_build();
        b = got.size();
        run_until(b + exp_q.size(), 200, 1'b0, ok);
        settle();
        checks++;
        if (!ok || got.size() !== b + exp_q.size()) begin
            errors++;
            $display("FAIL reset_count got=%0d want=%0d", got.size() - b, exp_q.size());
        end
        checks++;
        if (got.size() > b && got[b][CW+DSIZE-1:DSIZE] !== CW'(0)) begin
            errors++;
            $display("FAIL reset_first_grant got=%0d want=0", got[b][CW+DSIZE-1:DSIZE]);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (b + k >= got.size() || got[b+k] !== exp_q[k]) begin
                errors++;
                $display("FAIL reset_word%0d got=%h want=%h", k, (b + k < got.size()) ? got[b+k] : word_t'('x), exp_q[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        int b;
        bit ok;
        @(negedge rclk); #1;
        ch_en = '1;
        first_pop = -1;
        for (int i = 0; i < NCH; i++) load(i, 8);
        model_build();
        b = got.size();
        run_until(b + exp_q.size(), 400, 1'b0, ok);
        settle();
        checks++;
        if (!ok || got.size() !== b + exp_q.size()) begin
            errors++;
            $display("FAIL rr_count got=%0d want=%0d", got.size() - b, exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (b + k >= got.size() || got[b+k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rr_word%0d got=%h want=%h", k, (b + k < got.size()) ? got[b+k] : word_t'('x), exp_q[k]);
            end
        end
        checks++;
        if (got.size() > b + 4 && got[b+4][CW+DSIZE-1:DSIZE] !== CW'(1)) begin
            errors++;
            $display("FAIL rr_second_grant got=%0d want=1", got[b+4][CW+DSIZE-1:DSIZE]);
        end
        // 8 full grants: 31 pop-to-pop steps plus one idle cycle between each pair of grants
        checks++;
        if (last_pop - first_pop !== 38) begin
            errors++;
            $display("FAIL rr_throughput span=%0d want=38", last_pop - first_pop);
        end
        checks++;
        if (onehot_err !== 0) begin
            errors++;
            $display("FAIL rr_onehot violations=%0d want=0", onehot_err);
        end
    endtask

    task automatic test_early_drain();
        int b;
        int p1;
        bit ok;
        @(negedge rclk); #1;
        ch_en = '1;
        p1 = pop_cnt[1];
        load(1, 2);
        model_build();
        b = got.size();
        @(posedge rclk); #1;
        @(negedge rclk);
        @(negedge rclk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle_cycle busy=%b ov=%b want 1/0", busy, out_valid);
        end
        @(negedge rclk);
        checks++;
        if (out_valid !== 1'b1 || out_ch !== CW'(1)) begin
            errors++;
            $display("FAIL drain_latency ov=%b ch=%0d want 1/1", out_valid, out_ch);
        end
        @(negedge rclk);
        @(negedge rclk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit busy=%b want 0", busy);
        end
        #1;
        run_until(b + exp_q.size(), 100, 1'b0, ok);
        settle();
        checks++;
        if (!ok || got.size() !== b + 2 || pop_cnt[1] - p1 !== 2) begin
            errors++;
            $display("FAIL drain_count words=%0d pops=%0d want 2/2", got.size() - b, pop_cnt[1] - p1);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (b + k >= got.size() || got[b+k] !== exp_q[k]) begin
                errors++;
                $display("FAIL drain_word%0d got=%h want=%h", k, (b + k < got.size()) ? got[b+k] : word_t'('x), exp_q[k]);
            end
        end
        checks++;
        if (bad_pop !== 0) begin
            errors++;
            $display("FAIL drain_empty_pop count=%0d want=0", bad_pop);
        end
        @(negedge rclk); #1;
        for (int i = 0; i < NCH; i++) load(i, 1);
        model_build();
        b = got.size();
        run_until(b + exp_q.size(), 100, 1'b0, ok);
        settle();
        checks++;
        if (!ok || got.size() < b + 1 || got[b][CW+DSIZE-1:DSIZE] !== CW'(2)) begin
            errors++;
            $display("FAIL drain_rr_ptr first_ch=%0d want=2", (got.size() > b) ? int'(got[b][CW+DSIZE-1:DSIZE]) : -1);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (b + k >= got.size() || got[b+k] !== exp_q[k]) begin
                errors++;
                $display("FAIL drain_ptr_word%0d got=%h want=%h", k, (b + k < got.size()) ? got[b+k] : word_t'('x), exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int b;
        bit ok;
        @(negedge rclk); #1;
        ch_en = '1;
        load(2, 8);
        model_build();
        b = got.size();
        run_until(b + 2, 100, 1'b0, ok);
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge rclk);
            checks++;
            if (out_valid !== 1'b1 || out_ch !== CW'(2) || out_data !== exp_q[2][DSIZE-1:0] || rinc !== '0) begin
                errors++;
                $display("FAIL bp_stall%0d ov=%b ch=%0d d=%h rinc=%b want 1/2/%h/0", s, out_valid, out_ch, out_data, rinc, exp_q[2][DSIZE-1:0]);
            end
            @(posedge rclk); #1;
        end
        out_ready = 1'b1;
        run_until(b + exp_q.size(), 100, 1'b0, ok);
        settle();
        checks++;
        if (!ok || got.size() !== b + exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got=%0d want=%0d", got.size() - b, exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (b + k >= got.size() || got[b+k] !== exp_q[k]) begin
                errors++;
                $display("FAIL bp_word%0d got=%h want=%h", k, (b + k < got.size()) ? got[b+k] : word_t'('x), exp_q[k]);
            end
        end
        checks++;
        if (stall_pop !== 0 || hold_err !== 0) begin
            errors++;
            $display("FAIL bp_hold stall_pops=%0d hold_errs=%0d want 0/0", stall_pop, hold_err);
        end
    endtask

    task automatic test_disable();
        int b;
        int p0;
        bit ok;
        @(negedge rclk); #1;
        ch_en = 4'b1110;
        p0 = pop_cnt[0];
        load(0, 8);
        load(3, 1);
        model_build();
        b = got.size();
        run_until(b + exp_q.size(), 100, 1'b0, ok);
        settle();
        checks++;
        if (!ok || got.size() !== b + 1 || pop_cnt[0] !== p0) begin
            errors++;
            $display("FAIL dis_count words=%0d ch0_pops=%0d want 1/0", got.size() - b, pop_cnt[0] - p0);
        end
        checks++;
        if (got.size() < b + 1 || got[b] !== exp_q[0]) begin
            errors++;
            $display("FAIL dis_word got=%h want=%h", (got.size() > b) ? got[b] : word_t'('x), exp_q[0]);
        end
        @(negedge rclk); #1;
        clear_all();
        ch_en = '1;
        @(negedge rclk); #1;
        p0 = pop_cnt[1];
        load(1, 8);
        exp_q.delete();
        for (int j = 0; j < 3; j++) exp_q.push_back({CW'(1), fq[1][j]});
        b = got.size();
        run_until(b + 2, 100, 1'b0, ok);
        ch_en[1] = 1'b0;
        settle();
        checks++;
        if (!ok || got.size() !== b + 3 || pop_cnt[1] - p0 !== 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dismid_count words=%0d pops=%0d busy=%b want 3/3/0", got.size() - b, pop_cnt[1] - p0, busy);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b + k >= got.size() || got[b+k] !== exp_q[k]) begin
                errors++;
                $display("FAIL dismid_word%0d got=%h want=%h", k, (b + k < got.size()) ? got[b+k] : word_t'('x), exp_q[k]);
            end
        end
        @(negedge rclk); #1;
        clear_all();
        model_ptr = 2;
    endtask

    task automatic test_wrap();
        int b;
        bit ok;
        @(negedge rclk); #1;
        ch_en = '1;
        load(2, 1);
        model_build();
        b = got.size();
        run_until(b + 1, 100, 1'b0, ok);
        settle();
        @(negedge rclk); #1;
        load(3, 8);
        load(0, 8);
        model_build();
        b = got.size();
        run_until(b + exp_q.size(), 300, 1'b0, ok);
        settle();
        checks++;
        if (!ok || got.size() !== b + 16) begin
            errors++;
            $display("FAIL wrap_count got=%0d want=16", got.size() - b);
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (got.size() <= b + 4*g || got[b+4*g][CW+DSIZE-1:DSIZE] !== ((g % 2 == 0) ? CW'(3) : CW'(0))) begin
                errors++;
                $display("FAIL wrap_grant%0d got=%0d want=%0d", g, (got.size() > b + 4*g) ? int'(got[b+4*g][CW+DSIZE-1:DSIZE]) : -1, (g % 2 == 0) ? 3 : 0);
            end
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (b + k >= got.size() || got[b+k] !== exp_q[k]) begin
                errors++;
                $display("FAIL wrap_word%0d got=%h want=%h", k, (b + k < got.size()) ? got[b+k] : word_t'('x), exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        int b;
        bit ok;
        for (int r = 0; r < 5; r++) begin
            @(negedge rclk); #1;
            ch_en = NCH'($urandom);
            for (int i = 0; i < NCH; i++) load(i, $urandom_range(0, 9));
            model_build();
            b = got.size();
            run_until(b + exp_q.size(), 1000, 1'b1, ok);
            settle();
            checks++;
            if (!ok || got.size() !== b + exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_count got=%0d want=%0d", r, got.size() - b, exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (b + k >= got.size() || got[b+k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rnd%0d_word%0d got=%h want=%h", r, k, (b + k < got.size()) ? got[b+k] : word_t'('x), exp_q[k]);
                end
            end
            @(negedge rclk); #1;
            clear_all();
        end
        checks++;
        if (onehot_err !== 0 || bad_pop !== 0 || stall_pop !== 0 || hold_err !== 0) begin
            errors++;
            $display("FAIL rnd_protocol onehot=%0d bad_pop=%0d stall_pop=%0d hold=%0d want all 0", onehot_err, bad_pop, stall_pop, hold_err);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_early_drain();
        test_backpressure();
        test_disable();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
